hwpf_stride_dispatcher: RTL
===========================

# hwpf_stride_dispatcher

Consumer side of the prefetch request queue: pops one `prefethcing_engine_entry_t` at a time from the HPDC prefetcher FIFO, waits for a free stride prefetch engine, and programs that engine's throttle, param, and base configuration registers in that order. It sits between the queue and the engine register bank. Base is always written last, so an engine is only armed after it is fully configured.

## Interface
Parameters:
- `NUM_ENGINES`, default `` `NUM_HW_PREFETCH `` (4): number of stride engines; must be ≤ 16.
- `TIMEOUT_CYCLES`, default 256: maximum number of WAIT_FREE cycles before an entry is dropped (only with the timeout macro).
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `entry_valid_i` in 1: the queue holds an entry.
- `entry_ready_o` out 1: the dispatcher accepts the entry this cycle.
- `entry_i` in 160: `prefethcing_engine_entry_t` (base, param, throttle).
- `status_i` in 64: `hwpf_stride_status_t` from the engine bank.
- `cfg_req_valid_o` out 1: register write request.
- `cfg_req_ready_i` in 1: the register bank accepts the write.
- `cfg_req_engine_o` out `$clog2(NUM_ENGINES)`: target engine.
- `cfg_req_reg_o` out 2: register select; 0 = base, 1 = param, 2 = throttle.
- `cfg_req_wdata_o` out 64: write data.
- `busy_o` out 1: the FSM is not in IDLE.
- `dispatch_count_o` out `CNT_WIDTH`: number of completed dispatches; saturating.
- `drop_count_o` out `CNT_WIDTH`: number of discarded entries; saturating.

## Operation
FSM states: IDLE, WAIT_FREE, WR_THROTTLE, WR_PARAM, WR_BASE, COOLDOWN.

- **IDLE**
  - `entry_ready_o` = 1 only in this state.
  - On `entry_valid_i && entry_ready_o`, latch `entry_i` into the holding register.
  - If latched `base.enable` = 0: `drop_count`++, stay in IDLE.
  - Otherwise go to WAIT_FREE.
- **WAIT_FREE**
  - When `status_i.free` = 1 and `status_i.free_index` < `NUM_ENGINES`, latch `free_index` as the target engine and go to WR_THROTTLE.
  - A `free_index` ≥ `NUM_ENGINES` is treated as not free.
- **WR_THROTTLE**: `wdata` = `{32'b0, throttle}`, `reg` = 2.
- **WR_PARAM**: `wdata` = param, `reg` = 1.
- **WR_BASE**: `wdata` = base with bit 0 (enable) forced to 1; `rearm` and `cycle` are passed through unchanged; `reg` = 0.
- Each WR_* state holds `cfg_req_valid_o` = 1 with stable payload until `cfg_req_ready_i`. On the handshake, advance to the next state.
- The WR_BASE handshake increments `dispatch_count` and goes to COOLDOWN.
- **COOLDOWN**: one cycle, then IDLE. This guarantees `status_i` reflects the newly armed engine before the next WAIT_FREE sample.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset values: `entry_ready_o` = 0 during reset, 1 after the first clock in IDLE. All other outputs are 0: `cfg_req_valid_o`, `cfg_req_engine_o`, `cfg_req_reg_o`, `cfg_req_wdata_o`, `busy_o`, `dispatch_count_o`, `drop_count_o`.
- Minimum latency, with the entry accepted at cycle T, `status_i.free` already 1, and `cfg_req_ready_i` tied 1:
  - T+1: WAIT_FREE.
  - T+2: throttle write.
  - T+3: param write.
  - T+4: base write.
  - T+5: COOLDOWN.
  - T+6: IDLE, ready for the next entry.
- Peak throughput is one entry per 6 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to `cfg_req_*`.
- `status_i` changing during WR_* states is ignored; the target engine is fixed once latched.
- Reset asserted mid-operation returns the FSM to IDLE immediately and discards the held entry. An engine that was partially written is never armed, because base was not yet written.
- `cfg_req_ready_i` asserted outside WR_* states is ignored.

## Configuration
- `HWPF_DISPATCH_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entry to WAIT_FREE and increments on every cycle spent there.
  - When it reaches `TIMEOUT_CYCLES` with no free engine, the entry is discarded, `drop_count`++, and the FSM goes to IDLE.
- Undefined:
  - WAIT_FREE waits indefinitely.
  - `drop_count_o` counts only `enable` = 0 entries.

## Test plan
- **Single dispatch**: entry `{base=0x8000_0001, param=0x0002_0004_0000_0040, throttle=0x0001_0008}`, `free`=1, `free_index`=2, `cfg_req_ready_i`=1 → writes to engine 2 on cycles T+2, T+3, T+4:
  - `reg` 2 / `wdata 0x0000_0000_0001_0008`;
  - `reg` 1 / `wdata 0x0002_0004_0000_0040`;
  - `reg` 0 / `wdata 0x8000_0001`;
  - then `dispatch_count_o` = 1 and `entry_ready_o` = 1 at T+6.
- **Backpressure**: `cfg_req_ready_i` low for 5 cycles in WR_PARAM → valid, reg, and wdata stay stable for those 5 cycles; exactly 3 writes total.
- **No free engine**: `free`=0 for 100 cycles, then `free_index`=1 → stays in WAIT_FREE, writes go to engine 1; `free_index`=7 with `NUM_ENGINES`=4 is ignored.
- **Disabled entry**: `base.enable`=0 → no `cfg_req_valid_o`, `drop_count_o` = 1, ready again the next cycle.
- **Timeout**: with the macro and `TIMEOUT_CYCLES`=256, `free` never asserts → drop after 256 WAIT_FREE cycles, `drop_count_o` = 1. Without the macro, no drop after 1000 cycles.
- **Reset mid-write**: `rst_ni` low during WR_PARAM → all outputs 0 asynchronously; no base write afterwards; counters reset to 0.

Source files
------------

// File: rtl/hwpf_stride_dispatcher_if.sv
// Queue-pop and engine-register-write bundle for hwpf_stride_dispatcher.
// Layouts: entry_i = {base[63:0], param[63:0], throttle[31:0]}; status_i[0] = free, status_i[7:4] = free_index.
`ifndef NUM_HW_PREFETCH
`define NUM_HW_PREFETCH 4
`endif

interface hwpf_stride_dispatcher_if #(
  parameter int NUM_ENGINES = `NUM_HW_PREFETCH
);
  localparam int ENG_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  logic             entry_valid_i;
  logic             entry_ready_o;
  logic [159:0]     entry_i;
  logic [63:0]      status_i;
  logic             cfg_req_valid_o;
  logic             cfg_req_ready_i;
  logic [ENG_W-1:0] cfg_req_engine_o;
  logic [1:0]       cfg_req_reg_o;
  logic [63:0]      cfg_req_wdata_o;

  modport master (
    input  entry_valid_i, entry_i, status_i, cfg_req_ready_i,
    output entry_ready_o, cfg_req_valid_o, cfg_req_engine_o, cfg_req_reg_o, cfg_req_wdata_o
  );

  modport slave (
    output entry_valid_i, entry_i, status_i, cfg_req_ready_i,
    input  entry_ready_o, cfg_req_valid_o, cfg_req_engine_o, cfg_req_reg_o, cfg_req_wdata_o
  );
endinterface

// File: rtl/hwpf_stride_dispatcher.sv
// Pops prefetch entries and programs a free stride engine: throttle, param, then base (arming it last).
// Optional feature macro: HWPF_DISPATCH_TIMEOUT_EN drops entries that wait TIMEOUT_CYCLES for a free engine.
`ifndef NUM_HW_PREFETCH
`define NUM_HW_PREFETCH 4
`endif

module hwpf_stride_dispatcher #(
  parameter int NUM_ENGINES    = `NUM_HW_PREFETCH,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  hwpf_stride_dispatcher_if.master bus,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] dispatch_count_o,
  output logic [CNT_WIDTH-1:0] drop_count_o
);
  localparam int ENG_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_FREE   = 3'd1;
  localparam logic [2:0] ST_WR_THROTTLE = 3'd2;
  localparam logic [2:0] ST_WR_PARAM    = 3'd3;
  localparam logic [2:0] ST_WR_BASE     = 3'd4;
  localparam logic [2:0] ST_COOLDOWN    = 3'd5;

  localparam logic [1:0] REG_BASE     = 2'd0;
  localparam logic [1:0] REG_PARAM    = 2'd1;
  localparam logic [1:0] REG_THROTTLE = 2'd2;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [2:0]           state_r, state_nxt_s;
  logic [159:0]         entry_r;
  logic [ENG_W-1:0]     engine_r, engine_nxt_s;
  logic                 entry_ready_r, busy_r, cfg_valid_r;
  logic [ENG_W-1:0]     cfg_engine_r;
  logic [1:0]           cfg_reg_r, cfg_reg_nxt_s;
  logic [63:0]          cfg_wdata_r, cfg_wdata_nxt_s;
  logic [CNT_WIDTH-1:0] dispatch_cnt_r, drop_cnt_r;
  logic                 accept_s, hs_s, free_ok_s, drop_s, dispatch_s, wr_nxt_s, timeout_s;
  logic [3:0]           free_index_s;
  logic                 unused_status_s;

  assign free_index_s    = bus.status_i[7:4];
  assign free_ok_s       = bus.status_i[0] && (int'({28'd0, free_index_s}) < NUM_ENGINES);
  assign accept_s        = bus.entry_valid_i && entry_ready_r;
  assign hs_s            = cfg_valid_r && bus.cfg_req_ready_i;
  assign unused_status_s = ^{bus.status_i[63:8], bus.status_i[3:1]};

`ifdef HWPF_DISPATCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] wait_cnt_r;

  assign timeout_s = (wait_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in WAIT_FREE; zero whenever the FSM is elsewhere so it starts fresh on entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r != ST_WAIT_FREE) begin
      wait_cnt_r <= {TMO_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + TMO_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; cfg_req_ready_i only matters through hs_s, which is gated by WR_* state
  always_comb begin
    state_nxt_s  = state_r;
    engine_nxt_s = engine_r;
    drop_s       = 1'b0;
    dispatch_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && bus.entry_i[96]) begin
          state_nxt_s = ST_WAIT_FREE;
        end else if (accept_s) begin
          drop_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_FREE: begin
        if (free_ok_s) begin
          state_nxt_s  = ST_WR_THROTTLE;
          engine_nxt_s = free_index_s[ENG_W-1:0];
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          drop_s      = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_FREE;
        end
      end
      ST_WR_THROTTLE: begin
        if (hs_s) state_nxt_s = ST_WR_PARAM;
        else      state_nxt_s = ST_WR_THROTTLE;
      end
      ST_WR_PARAM: begin
        if (hs_s) state_nxt_s = ST_WR_BASE;
        else      state_nxt_s = ST_WR_PARAM;
      end
      ST_WR_BASE: begin
        if (hs_s) begin
          state_nxt_s = ST_COOLDOWN;
          dispatch_s  = 1'b1;
        end else begin
          state_nxt_s = ST_WR_BASE;
        end
      end
      ST_COOLDOWN: state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Payload decoded from the next state so the registered outputs line up with the state they describe
  always_comb begin
    wr_nxt_s        = 1'b1;
    cfg_reg_nxt_s   = 2'd0;
    cfg_wdata_nxt_s = 64'd0;
    case (state_nxt_s)
      ST_WR_THROTTLE: begin
        cfg_reg_nxt_s   = REG_THROTTLE;
        cfg_wdata_nxt_s = {32'd0, entry_r[31:0]};
      end
      ST_WR_PARAM: begin
        cfg_reg_nxt_s   = REG_PARAM;
        cfg_wdata_nxt_s = entry_r[95:32];
      end
      ST_WR_BASE: begin
        cfg_reg_nxt_s   = REG_BASE;
        cfg_wdata_nxt_s = entry_r[159:96] | 64'd1;
      end
      default: wr_nxt_s = 1'b0;
    endcase
  end

  // State, held entry and target engine
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      entry_r  <= 160'd0;
      engine_r <= {ENG_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      engine_r <= engine_nxt_s;
      if (accept_s) entry_r <= bus.entry_i;
      else          entry_r <= entry_r;
    end
  end

  // Registered outputs and saturating statistics
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_ready_r  <= 1'b0;
      busy_r         <= 1'b0;
      cfg_valid_r    <= 1'b0;
      cfg_engine_r   <= {ENG_W{1'b0}};
      cfg_reg_r      <= 2'd0;
      cfg_wdata_r    <= 64'd0;
      dispatch_cnt_r <= {CNT_WIDTH{1'b0}};
      drop_cnt_r     <= {CNT_WIDTH{1'b0}};
    end else begin
      entry_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r         <= (state_nxt_s != ST_IDLE);
      cfg_valid_r    <= wr_nxt_s;
      cfg_engine_r   <= wr_nxt_s ? engine_nxt_s : {ENG_W{1'b0}};
      cfg_reg_r      <= cfg_reg_nxt_s;
      cfg_wdata_r    <= cfg_wdata_nxt_s;
      dispatch_cnt_r <= dispatch_s ? sat_inc(dispatch_cnt_r) : dispatch_cnt_r;
      drop_cnt_r     <= drop_s ? sat_inc(drop_cnt_r) : drop_cnt_r;
    end
  end

  assign bus.entry_ready_o    = entry_ready_r;
  assign bus.cfg_req_valid_o  = cfg_valid_r;
  assign bus.cfg_req_engine_o = cfg_engine_r;
  assign bus.cfg_req_reg_o    = cfg_reg_r;
  assign bus.cfg_req_wdata_o  = cfg_wdata_r;
  assign busy_o               = busy_r;
  assign dispatch_count_o     = dispatch_cnt_r;
  assign drop_count_o         = drop_cnt_r;
endmodule
